trace_match_log: RTL
====================

TRACE_MATCH_LOG -- requirements
Module: trace_match_log

Interface
REQ-001 Parameter pMATCH_RULES, default 8: width of match-rule vector.
REQ-002 Parameter pFIFO_DEPTH, default 8: event FIFO entries; power of 2, at least 2.
REQ-003 Parameter pTS_WIDTH, default 16: timestamp width.
REQ-004 TRACECLK  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 I_match_bits  in  pMATCH_RULES  per-rule match strobes from the trace trigger stage; any nonzero bit in a cycle is one match event.
REQ-007 I_arm  in  1  level; high = armed, low = disarmed.
REQ-008 I_trig_count  in  8  matches required per trigger; 0 is treated as 1.
REQ-009 I_pulse_len  in  8  trigger pulse length in cycles; 0 is treated as 1.
REQ-010 I_holdoff  in  16  cycles after a pulse during which matches are not counted.
REQ-011 I_fifo_rd  in  1  pop strobe for the event FIFO.
REQ-012 O_trig  out  1  trigger pulse.
REQ-013 O_state  out  2  state: 0 IDLE, 1 ARMED, 2 PULSE, 3 HOLDOFF.
REQ-014 O_match_count  out  16  matches counted since arm; saturates at 0xFFFF.
REQ-015 O_fifo_data  out  pTS_WIDTH+pMATCH_RULES  head entry {timestamp, match_bits}, first-word-fall-through.
REQ-016 O_fifo_empty / O_fifo_full / O_fifo_overflow  out  1 each  FIFO status; overflow is sticky.

Function
REQ-017 IDLE: O_trig=0, timestamp held at 0, no counting, no logging; rising I_arm -> ARMED.
REQ-018 Arm rising edge (I_arm high, previous cycle low): clear timestamp, O_match_count, internal trigger count, FIFO contents and overflow flag in that cycle.
REQ-019 Timestamp: increments by 1 every cycle while not IDLE, starting at 0 the cycle after arm; wraps modulo 2^pTS_WIDTH.
REQ-020 Logging: each match event in any non-IDLE state pushes {timestamp, I_match_bits} into the FIFO; this includes PULSE and HOLDOFF.
REQ-021 O_match_count increments on every logged event.
REQ-022 ARMED: each match increments the internal trigger count. When the count reaches max(I_trig_count,1), the next cycle is PULSE, the count resets to 0, and O_trig=1.
REQ-023 PULSE: O_trig held high for exactly max(I_pulse_len,1) cycles. Then HOLDOFF if I_holdoff!=0, else ARMED. Matches are logged but not counted toward the trigger.
REQ-024 HOLDOFF: lasts exactly I_holdoff cycles with O_trig=0 and matches not counted, then ARMED.
REQ-025 I_arm low in any state -> IDLE the next cycle; O_trig=0 the same next cycle. FIFO contents are retained and remain readable.
REQ-026 FIFO push when full: entry dropped, O_fifo_overflow set (sticky until next arm rising edge or reset).
REQ-027 Pop when empty: ignored, no pointer change.
REQ-028 Simultaneous push and pop when full: both occur; no overflow; count unchanged.
REQ-029 Simultaneous push and pop when empty: the entry is written; pop ignored; the FIFO is non-empty next cycle.
REQ-030 O_fifo_data is valid whenever O_fifo_empty=0; the new head appears the cycle after a pop.
REQ-031 Config inputs are sampled on entry to each state; mid-state changes take effect at the next entry.

Reset
REQ-032 Reset: state=IDLE, O_trig=0, O_state=0, O_match_count=0, timestamp=0, FIFO empty (O_fifo_empty=1, O_fifo_full=0), O_fifo_overflow=0, O_fifo_data=0.
REQ-033 Reset overrides all inputs and takes effect mid-pulse or mid-holdoff, with outputs per REQ-032 the next cycle.

Verification
REQ-034 Stimulus: arm; trig_count=3, pulse_len=4, holdoff=0; matches at ts 5,9,12. Required: O_trig high for ts 13..16; FIFO holds {5},{9},{12}.
REQ-035 Stimulus: trig_count=1, pulse_len=2, holdoff=10; a match during HOLDOFF. Required: the match is logged, O_match_count increments, and no second pulse occurs until a match in ARMED.
REQ-036 Stimulus: pFIFO_DEPTH=8; 10 matches, no reads. Required: full=1, overflow=1, first 8 entries retained; overflow clears on re-arm.
REQ-037 Stimulus: FIFO full, push and pop in the same cycle. Required: full stays 1, overflow stays 0, head advances.
REQ-038 Stimulus: disarm during PULSE. Required: O_trig=0 and O_state=IDLE next cycle; FIFO still readable.
REQ-039 Stimulus: trig_count=0, pulse_len=0. Required: each ARMED match gives a 1-cycle O_trig.

Source files
------------

// File: rtl/trace_match_log.sv
// Trace match logger: counts rule matches to fire a trigger pulse with holdoff,
// and timestamps every match into a first-word-fall-through event FIFO.
module trace_match_log #(
    parameter int pMATCH_RULES = 8,
    parameter int pFIFO_DEPTH  = 8,
    parameter int pTS_WIDTH    = 16
) (
    input  logic                              TRACECLK,
    input  logic                              reset,
    input  logic [pMATCH_RULES-1:0]           I_match_bits,
    input  logic                              I_arm,
    input  logic [7:0]                        I_trig_count,
    input  logic [7:0]                        I_pulse_len,
    input  logic [15:0]                       I_holdoff,
    input  logic                              I_fifo_rd,
    output logic                              O_trig,
    output logic [1:0]                        O_state,
    output logic [15:0]                       O_match_count,
    output logic [pTS_WIDTH+pMATCH_RULES-1:0] O_fifo_data,
    output logic                              O_fifo_empty,
    output logic                              O_fifo_full,
    output logic                              O_fifo_overflow
);

    localparam int cAW = (pFIFO_DEPTH > 1) ? $clog2(pFIFO_DEPTH) : 1;
    localparam int cDW = pTS_WIDTH + pMATCH_RULES;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PULSE   = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_arm_d;
    logic [pTS_WIDTH-1:0] r_ts;
    logic [7:0]           r_trig_target;
    logic [7:0]           r_trig_cnt;
    logic [15:0]          r_timer;
    logic [15:0]          r_match_count;
    logic [cDW-1:0]       r_mem [pFIFO_DEPTH];
    logic [cAW:0]         r_wr_ptr;
    logic [cAW:0]         r_rd_ptr;
    logic                 r_overflow;

    logic w_arm_rise, w_log, w_trig_hit, w_timer_done;
    logic w_empty, w_full, w_pop, w_push, w_drop;
    logic w_enter_armed, w_enter_pulse, w_enter_holdoff;

    assign w_arm_rise   = I_arm & ~r_arm_d;
    assign w_log        = (|I_match_bits) && (r_state != IDLE);
    assign w_trig_hit   = ({1'b0, r_trig_cnt} + 9'd1) >= {1'b0, r_trig_target};
    assign w_timer_done = (r_timer == 16'd0);

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[cAW] != r_rd_ptr[cAW]) &&
                     (r_wr_ptr[cAW-1:0] == r_rd_ptr[cAW-1:0]);
    assign w_pop   = I_fifo_rd && !w_empty;
    assign w_push  = w_log && (!w_full || w_pop);
    assign w_drop  = w_log && w_full && !w_pop;

    always_comb begin
        w_next          = r_state;
        w_enter_armed   = 1'b0;
        w_enter_pulse   = 1'b0;
        w_enter_holdoff = 1'b0;
        if (r_state == IDLE) begin
            if (w_arm_rise) begin
                w_next        = ARMED;
                w_enter_armed = 1'b1;
            end
        end else if (!I_arm) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                ARMED: begin
                    if (w_log && w_trig_hit) begin
                        w_next        = PULSE;
                        w_enter_pulse = 1'b1;
                    end
                end
                PULSE: begin
                    if (w_timer_done) begin
                        if (I_holdoff != 16'd0) begin
                            w_next          = HOLDOFF;
                            w_enter_holdoff = 1'b1;
                        end else begin
                            w_next        = ARMED;
                            w_enter_armed = 1'b1;
                        end
                    end
                end
                HOLDOFF: begin
                    if (w_timer_done) begin
                        w_next        = ARMED;
                        w_enter_armed = 1'b1;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge TRACECLK) begin
        if (reset) begin
            r_state       <= IDLE;
            r_arm_d       <= 1'b0;
            r_ts          <= '0;
            r_trig_target <= 8'd1;
            r_trig_cnt    <= 8'd0;
            r_timer       <= 16'd0;
            r_match_count <= 16'd0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_arm_d <= I_arm;

            // Timestamp sits at 0 throughout IDLE so ARMED always starts counting from 0.
            if (r_state == IDLE || w_next == IDLE) begin
                r_ts <= '0;
            end else begin
                r_ts <= r_ts + pTS_WIDTH'(1);
            end

            if (w_enter_armed) begin
                r_trig_cnt    <= 8'd0;
                r_trig_target <= (I_trig_count == 8'd0) ? 8'd1 : I_trig_count;
            end else if (r_state == ARMED && w_log) begin
                r_trig_cnt <= w_trig_hit ? 8'd0 : r_trig_cnt + 8'd1;
            end

            // Timer holds remaining cycles minus one; the state ends on the cycle it reads zero.
            if (w_enter_pulse) begin
                r_timer <= (I_pulse_len == 8'd0) ? 16'd0 : 16'(I_pulse_len) - 16'd1;
            end else if (w_enter_holdoff) begin
                r_timer <= I_holdoff - 16'd1;
            end else if (!w_timer_done) begin
                r_timer <= r_timer - 16'd1;
            end

            if (w_arm_rise) begin
                r_match_count <= 16'd0;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_overflow    <= 1'b0;
            end else begin
                if (w_log && r_match_count != 16'hFFFF) begin
                    r_match_count <= r_match_count + 16'd1;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + (cAW+1)'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + (cAW+1)'(1);
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge TRACECLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[cAW-1:0]] <= {r_ts, I_match_bits};
        end
    end

    assign O_trig          = (r_state == PULSE);
    assign O_state         = r_state;
    assign O_match_count   = r_match_count;
    assign O_fifo_data     = w_empty ? '0 : r_mem[r_rd_ptr[cAW-1:0]];
    assign O_fifo_empty    = w_empty;
    assign O_fifo_full     = w_full;
    assign O_fifo_overflow = r_overflow;

endmodule
